// File: rtl/mac_pkg.sv
// Shared MAC constants, rx FSM state type and Ethernet CRC-32 helpers
// (reflected polynomial, LSB-first bit order).
package mac_pkg;

  localparam int MAC_MIN_FRAME  = 64;
  localparam int MAC_MAX_FRAME  = 1518;
  localparam int MAC_FCS_BYTES  = 4;
  localparam int MAC_MIN_PREFCS = MAC_MIN_FRAME - MAC_FCS_BYTES;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_STATUS} rx_state_e;

  function automatic logic [31:0] crc32_eth_init();
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] crc32_eth_update(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] crc32_eth_final(input logic [31:0] crc);
    return ~crc;
  endfunction

endpackage

// File: rtl/mac_rx_delay4.sv
// Four-entry byte shift register; q[0] is the oldest byte.
module mac_rx_delay4
  import mac_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      din,
  output logic [3:0][7:0] q,
  output logic [2:0]      fill
);

  logic [2:0] wr_idx;
  assign wr_idx = pop ? (fill - 3'd1) : fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else begin
      if (pop)
        for (int i = 0; i < MAC_FCS_BYTES - 1; i++) q[i] <= q[i+1];
      // later write wins over the shift for the refilled slot
      if (push && (pop || fill < 3'(MAC_FCS_BYTES)))
        q[wr_idx[1:0]] <= din;
      if (push && !pop)      fill <= fill + 3'd1;
      else if (pop && !push) fill <= fill - 3'd1;
    end
  end

endmodule

// File: rtl/mac_rx_fcs_check.sv
// Rx FCS strip/check: 4-byte delay line holds back the FCS, CRC runs on popped bytes.
// Define MAC_RX_STATS_EN to add frame/error counters.
module mac_rx_fcs_check
  import mac_pkg::*;
#(
  parameter int MIN_FRAME = MAC_MIN_FRAME,
  parameter int MAX_FRAME = MAC_MAX_FRAME
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        stat_valid,
  output logic        stat_crc_err,
  output logic        stat_runt,
  output logic        stat_oversize,
  output logic [15:0] stat_len
`ifdef MAC_RX_STATS_EN
  ,
  output logic [31:0] frames_ok_cnt,
  output logic [31:0] crc_err_cnt,
  output logic [31:0] len_err_cnt
`endif
);

  rx_state_e       state;
  logic [31:0]     crc;
  logic [15:0]     count;
  logic [3:0][7:0] dly_q;
  logic [2:0]      fill;

  logic        acc, streaming, crc_bad;
  logic [31:0] crc_pop, fcs_rx;
  logic [15:0] len_n;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_FILL:   in_ready = 1'b1;
      S_STREAM: in_ready = out_ready;
      default:  in_ready = 1'b0;
    endcase
  end

  assign streaming = (state == S_STREAM);
  assign acc       = in_valid & in_ready;
  assign out_valid = streaming & in_valid;
  assign out_last  = out_valid & in_last;
  assign out_data  = dly_q[0];

  // On the last byte the FCS is the three youngest buffered bytes plus in_data.
  assign crc_pop = crc32_eth_update(crc, dly_q[0]);
  assign fcs_rx  = {in_data, dly_q[3], dly_q[2], dly_q[1]};
  assign crc_bad = !streaming || (fcs_rx != crc32_eth_final(crc_pop));
  assign len_n   = (count == 16'hFFFF) ? count : count + 16'd1;

  mac_rx_delay4 u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc & in_last),
    .push  (acc),
    .pop   (acc & streaming),
    .din   (in_data),
    .q     (dly_q),
    .fill  (fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FILL;
      crc           <= crc32_eth_init();
      count         <= '0;
      stat_valid    <= 1'b0;
      stat_crc_err  <= 1'b0;
      stat_runt     <= 1'b0;
      stat_oversize <= 1'b0;
      stat_len      <= '0;
    end else begin
      stat_valid <= 1'b0;
      case (state)
        S_STATUS: state <= S_FILL;
        default: if (acc) begin
          if (streaming) crc <= crc_pop;
          count <= len_n;
          if (in_last) begin
            state         <= S_STATUS;
            crc           <= crc32_eth_init();
            count         <= '0;
            stat_valid    <= 1'b1;
            stat_crc_err  <= crc_bad;
            stat_runt     <= int'(len_n) < MIN_FRAME;
            stat_oversize <= int'(len_n) > MAX_FRAME;
            stat_len      <= len_n;
          end else if (!streaming && fill == 3'd3) begin
            state <= S_STREAM;
          end
        end
      endcase
    end
  end

`ifdef MAC_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_ok_cnt <= '0;
      crc_err_cnt   <= '0;
      len_err_cnt   <= '0;
    end else if (stat_valid) begin
      if (!(stat_crc_err || stat_runt || stat_oversize)) frames_ok_cnt <= frames_ok_cnt + 32'd1;
      if (stat_crc_err)               crc_err_cnt <= crc_err_cnt + 32'd1;
      if (stat_runt || stat_oversize) len_err_cnt <= len_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Scoreboard bench for mac_rx_fcs_check: random frames, reference CRC from the
// normal-form polynomial, expected bytes/status queued and checked by a monitor.
module tb_mac_rx_fcs_check;

  typedef struct packed {
    logic        crc_err;
    logic        runt;
    logic        oversize;
    logic [15:0] len;
  } stat_t;

  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, in_last = 0;
  logic [7:0]  in_data = 0;
  logic        out_valid, out_ready = 1, out_last;
  logic [7:0]  out_data;
  logic        stat_valid, stat_crc_err, stat_runt, stat_oversize;
  logic [15:0] stat_len;
`ifdef MAC_RX_STATS_EN
  logic [31:0] frames_ok_cnt, crc_err_cnt, len_err_cnt;
  int m_ok = 0, m_crc = 0, m_len = 0;
`endif

  int n_cmp = 0, n_err = 0;
  bit slow = 0;
  logic [8:0] exp_q[$];
  stat_t      st_q[$];

  mac_rx_fcs_check dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .stat_valid(stat_valid), .stat_crc_err(stat_crc_err), .stat_runt(stat_runt),
    .stat_oversize(stat_oversize), .stat_len(stat_len)
`ifdef MAC_RX_STATS_EN
    , .frames_ok_cnt(frames_ok_cnt), .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CRC-32 in non-reflected form, bits fed LSB first, result bit-reversed.
  function automatic logic [31:0] ref_fcs(input logic [7:0] f[$], input int n);
    logic [31:0] c, r;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[31] ^ f[i][b];
        c = c << 1;
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    c = ~c;
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return r;
  endfunction

  function automatic void make_frame(input int n_pre, input int bad_fcs_byte, output logic [7:0] f[$]);
    logic [31:0] fcs;
    f = {};
    for (int i = 0; i < n_pre; i++) f.push_back(8'($urandom));
    fcs = ref_fcs(f, n_pre);
    for (int k = 0; k < 4; k++)
      f.push_back(fcs[8*k +: 8] ^ ((k == bad_fcs_byte) ? 8'h01 : 8'h00));
  endfunction

  task automatic expect_frame(input logic [7:0] f[$], input int stop_after);
    int    l;
    stat_t s;
    l = f.size();
    if (stop_after > 0) begin
      for (int i = 0; i < stop_after - 4; i++) exp_q.push_back({1'b0, f[i]});
      return;
    end
    for (int i = 0; i < l - 4; i++) exp_q.push_back({i == l - 5, f[i]});
    s.crc_err  = (l <= 4) || ({f[l-1], f[l-2], f[l-3], f[l-4]} != ref_fcs(f, l - 4));
    s.runt     = l < 64;
    s.oversize = l > 1518;
    s.len      = (l > 65535) ? 16'hFFFF : 16'(l);
    st_q.push_back(s);
`ifdef MAC_RX_STATS_EN
    if (!(s.crc_err || s.runt || s.oversize)) m_ok++;
    if (s.crc_err) m_crc++;
    if (s.runt || s.oversize) m_len++;
`endif
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic send_frame(input logic [7:0] f[$], input bit gaps, input int stop_after);
    int n;
    n = (stop_after > 0) ? stop_after : f.size();
    for (int i = 0; i < n; i++) begin
      bit ok;
      int budget;
      ok = 0;
      budget = 0;
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      in_data  = f[i];
      in_last  = (i == f.size() - 1);
      while (!ok) begin
        #1 ok = in_ready;
        @(negedge clk);
        budget++;
        if (!ok && budget > 200) begin
          chk("in_accept_timeout", 32'(budget), 32'(0));
          in_valid = 0;
          in_last  = 0;
          return;
        end
      end
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic run(input logic [7:0] f[$], input bit gaps);
    expect_frame(f, 0);
    send_frame(f, gaps, 0);
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_stat"}, {12'h0, stat_valid, stat_crc_err, stat_runt, stat_oversize, stat_len},
        32'h0);
  endtask

  always @(posedge clk) begin
    #2 out_ready = slow ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (out_valid) chk("in_ready_tracks_out_ready", 32'(in_ready), 32'(out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out_byte", {23'h0, out_last, out_data}, 32'h1FF);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_byte", {23'h0, out_last, out_data}, {23'h0, e});
        end
      end
      if (stat_valid) begin
        stat_t a;
        a = '{stat_crc_err, stat_runt, stat_oversize, stat_len};
        if (st_q.size() == 0) chk("unexpected_stat", {13'h0, a}, 32'h7FFFF);
        else begin
          stat_t e;
          e = st_q.pop_front();
          chk("stat", {13'h0, a}, {13'h0, e});
        end
      end
    end
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] base[$];
    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    rst_n = 1;
    @(negedge clk);

    make_frame(60, -1, base);
    run(base, 0);                                  // good minimum frame
    f = base; f[62] = f[62] ^ 8'h01; run(f, 0);    // corrupted FCS byte 2
    f = {8'hAA, 8'hBB, 8'hCC}; run(f, 0);          // 3-byte runt
    make_frame(1515, -1, f); run(f, 0);            // oversize, good FCS
    slow = 1; run(base, 1); slow = 0;              // backpressure and gaps

    make_frame(60, -1, f);                         // reset after byte 20
    expect_frame(f, 20);
    send_frame(f, 0, 20);
    rst_n = 0;
    @(negedge clk);
    check_reset_state("rst_mid");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    make_frame(60, -1, f); run(f, 0);

    for (int i = 0; i < 12; i++) begin
      int n;
      n = $urandom_range(0, 70);
      make_frame(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, f);
      if ($urandom_range(0, 1) == 1) begin
        slow = 1; run(f, 1); slow = 0;
      end else run(f, 0);
    end

    for (int t = 0; t < 3000 && (exp_q.size() != 0 || st_q.size() != 0); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("bytes_drained", 32'(exp_q.size()), 32'(0));
    chk("stats_drained", 32'(st_q.size()), 32'(0));
`ifdef MAC_RX_STATS_EN
    chk("frames_ok_cnt", frames_ok_cnt, 32'(m_ok));
    chk("crc_err_cnt", crc_err_cnt, 32'(m_crc));
    chk("len_err_cnt", len_err_cnt, 32'(m_len));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
